// File: rtl/pl_pipe_chain.sv
// -----------------------------------------------------------------------------
// pl_pipe_chain
//   A chain of DEPTH valid/data stages, stage 0 youngest and stage DEPTH-1
//   oldest. Stages collapse holes: a younger entry moves into an empty (or
//   killed) slot ahead of it even while the output is back-pressured.
//   stall freezes every stage, bubble inserts a hole at stage 0, and
//   flush_mask kills selected stages at the coming edge.
//
// Handshake: a beat moves across an interface on a rising clk edge exactly
//   when valid and ready are both high in the cycle before that edge. The
//   valid side never depends on the ready side of the same interface. Once
//   presented, out_valid/out_data are held until taken, except that stall
//   masks out_valid and flush_mask may retract an entry.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    upstream beat present          in_ready   stage 0 can take it
//   in_data     upstream payload (WIDTH)
//   out_valid   oldest stage holds live data   out_ready  downstream takes it
//   out_data    oldest stage payload (WIDTH)
//   stall       freezes all stages
//   bubble      loads a hole into stage 0 and holds off upstream
//   flush_mask  bit i kills the stage-i entry at the coming edge
//   valid_vec   registered per-stage valid bits
//   occupancy   population count of valid_vec
//   stat_xfer   output transfers (saturating)
//   stat_bubble idle cycles: out_ready=1, stall=0, out_valid=0 (saturating)
//
// Build option
//   PL_PIPE_CHAIN_STATS_EN  when defined, stat_xfer/stat_bubble count;
//                           otherwise both are tied to zero with no flops.
// -----------------------------------------------------------------------------
module pl_pipe_chain #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             bubble,
  input  logic [DEPTH-1:0] flush_mask,
  output logic [DEPTH-1:0] valid_vec,
  output logic [OCC_W-1:0] occupancy,
  output logic [31:0]      stat_xfer,
  output logic [31:0]      stat_bubble
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH:0]   acc;

  // acc[i]: stage i may be written this edge, because its own entry is
  // absent/killed or will itself move on. Built from a scalar running OR
  // so the vector never reads back its own bits.
  always_comb begin
    logic run;
    live = v & ~flush_mask;
    acc  = '0;
    run  = out_ready & ~stall;
    acc[DEPTH] = run;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      run    = run | ~live[i];
      acc[i] = run;
    end
  end

  // rst gates in_ready so nothing looks acceptable while reset is held.
  assign in_ready  = rst & acc[0] & ~bubble & ~stall;
  assign out_valid = live[DEPTH-1] & ~stall;
  assign out_data  = d[DEPTH-1];
  assign valid_vec = v;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  // Stage update. Flush wins over both hold and advance because every
  // path takes the valid bit from live[], never from raw v[].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (stall) begin
      v <= live;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (acc[i]) begin
          v[i] <= live[i-1];
          d[i] <= d[i-1];
        end else begin
          v[i] <= live[i];
        end
      end
      if (acc[0]) begin
        // bubble drops in_ready, so stage 0 takes a hole here
        v[0] <= in_valid & in_ready;
        d[0] <= in_data;
      end else begin
        v[0] <= live[0];
      end
    end
  end

`ifdef PL_PIPE_CHAIN_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_xfer   <= '0;
      stat_bubble <= '0;
    end else begin
      if (out_valid && out_ready && (stat_xfer != 32'hFFFF_FFFF)) begin
        stat_xfer <= stat_xfer + 32'd1;
      end
      if (out_ready && !stall && !out_valid && (stat_bubble != 32'hFFFF_FFFF)) begin
        stat_bubble <= stat_bubble + 32'd1;
      end
    end
  end
`else
  assign stat_xfer   = '0;
  assign stat_bubble = '0;
`endif

endmodule
